// File: rtl/alu_pkg.sv
// Shared ALU control codes, arbiter state encoding and the legacy-code
// canonicalisation used when a request is latched.
package alu_pkg;

  localparam logic [5:0] ALU_ADD  = 6'd16;
  localparam logic [5:0] ALU_ADDI = 6'd8;
  localparam logic [5:0] ALU_SUB  = 6'd34;
  localparam logic [5:0] ALU_AND  = 6'd36;
  localparam logic [5:0] ALU_ANDI = 6'd12;
  localparam logic [5:0] ALU_OR   = 6'd35;
  localparam logic [5:0] ALU_ORI  = 6'd13;
  localparam logic [5:0] ALU_NOR  = 6'd39;
  localparam logic [5:0] ALU_SLT  = 6'd42;
  localparam logic [5:0] ALU_SLTI = 6'd10;
  localparam logic [5:0] ALU_BEQ  = 6'd4;
  localparam logic [5:0] ALU_BNE  = 6'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0] code;
    logic       illegal;
  } canon_t;

  // Immediate forms collapse onto their register forms; unknown codes become 0.
  function automatic canon_t canon_ctl(input logic [5:0] ctl);
    canon_t c;
    c.code    = ctl;
    c.illegal = 1'b0;
    case (ctl)
      ALU_ADDI: c.code = ALU_ADD;
      ALU_SLTI: c.code = ALU_SLT;
      ALU_ANDI: c.code = ALU_AND;
      ALU_ORI:  c.code = ALU_OR;
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_NOR, ALU_SLT, ALU_BEQ, ALU_BNE: c.code = ctl;
      default: begin
        c.code    = 6'd0;
        c.illegal = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Combinational two-way round-robin picker: on contention the port that
// did not win last time gets the grant.
module alu_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt_idx = 1'b0;
    gnt     = 2'b00;
    if (req == 2'b11) begin
      gnt_idx = ~last_gnt;
    end else begin
      gnt_idx = req[1];
    end
    if (req != 2'b00) begin
      gnt = gnt_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter/sequencer for the shared single-cycle alu: accept one
// request, run it for one cycle, hold the registered response for its owner.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [5:0]       req_ctl0,
  input  logic [5:0]       req_ctl1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_overflow,
  output logic             resp_illegal,
  output logic [5:0]       alu_control,
  output logic [WIDTH-1:0] alu_read1,
  output logic [WIDTH-1:0] alu_foutput,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output state_t           dbg_state
);

  // Handshakes: a request transfers on a cycle where req_valid[p] and
  // req_ready[p] are both 1; a response transfers where resp_valid[p] and
  // resp_ready[p] are both 1. Valid must not depend on ready.

  state_t     state;
  logic       last_gnt;
  logic       owner;
  logic       illegal_q;
  logic [1:0] gnt;
  logic       gnt_idx;
  logic [5:0] sel_ctl;
  canon_t     sel_canon;
  logic       is_branch;

  alu_rr_arb2 u_arb (
    .req      (req_valid),
    .last_gnt (last_gnt),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  assign req_ready = ((state == S_IDLE) && rst_n) ? gnt : 2'b00;
  assign sel_ctl   = gnt_idx ? req_ctl1 : req_ctl0;
  assign sel_canon = canon_ctl(sel_ctl);
  assign is_branch = (alu_control == ALU_BEQ) || (alu_control == ALU_BNE);
  assign dbg_state = state;

  // alu_control holds the canonical code for the whole EXEC cycle, so the
  // flag masks below key off it directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      last_gnt      <= 1'b1;
      owner         <= 1'b0;
      illegal_q     <= 1'b0;
      resp_valid    <= 2'b00;
      resp_result   <= '0;
      resp_zero     <= 1'b0;
      resp_overflow <= 1'b0;
      resp_illegal  <= 1'b0;
      alu_control   <= 6'd0;
      alu_read1     <= '0;
      alu_foutput   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_ready != 2'b00) begin
            state       <= S_EXEC;
            owner       <= gnt_idx;
            last_gnt    <= gnt_idx;
            illegal_q   <= sel_canon.illegal;
            alu_control <= sel_canon.code;
            alu_read1   <= gnt_idx ? req_a1 : req_a0;
            alu_foutput <= gnt_idx ? req_b1 : req_b0;
          end
        end
        S_EXEC: begin
          state         <= S_RESP;
          resp_valid    <= owner ? 2'b10 : 2'b01;
          resp_illegal  <= illegal_q;
          resp_result   <= (illegal_q || is_branch) ? '0 : alu_out;
          resp_zero     <= is_branch & alu_zero;
          resp_overflow <= (alu_control == ALU_ADD) & alu_overflow;
          alu_control   <= 6'd0;
          alu_read1     <= '0;
          alu_foutput   <= '0;
        end
        S_RESP: begin
          if (resp_ready[owner]) begin
            state      <= S_IDLE;
            resp_valid <= 2'b00;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic
// scored against a behavioural model of the arbiter and of the alu.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [5:0]   code;
    logic         illegal;
    logic         ovf;
    logic         zero;
    logic [W-1:0] result;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready = 2'b00;
  logic [W-1:0] resp_result;
  logic         resp_zero, resp_overflow, resp_illegal;
  logic [5:0]   alu_control;
  logic [W-1:0] alu_read1, alu_foutput, alu_out;
  logic         alu_zero, alu_overflow;
  logic [W:0]   alu_sum;
  state_t       dbg_state;

  logic [5:0]   cur_ctl [2];
  logic [W-1:0] cur_a [2];
  logic [W-1:0] cur_b [2];
  logic         accepted [2];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  // Model of the arbiter's externally visible behaviour.
  exp_t exp_q[$];
  logic m_busy = 1'b0;
  logic m_owner = 1'b0;
  logic m_last = 1'b1;
  int   m_hs = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk (clk), .rst_n (rst_n),
    .req_valid (req_valid), .req_ready (req_ready),
    .req_ctl0 (cur_ctl[0]), .req_ctl1 (cur_ctl[1]),
    .req_a0 (cur_a[0]), .req_a1 (cur_a[1]),
    .req_b0 (cur_b[0]), .req_b1 (cur_b[1]),
    .resp_valid (resp_valid), .resp_ready (resp_ready),
    .resp_result (resp_result), .resp_zero (resp_zero),
    .resp_overflow (resp_overflow), .resp_illegal (resp_illegal),
    .alu_control (alu_control), .alu_read1 (alu_read1), .alu_foutput (alu_foutput),
    .alu_out (alu_out), .alu_zero (alu_zero), .alu_overflow (alu_overflow),
    .dbg_state (dbg_state)
  );

  // Stand-in for the external alu; deliberately noisy flags and a garbage
  // result for codes where the arbiter must mask them.
  always_comb begin
    alu_out = '0;
    alu_sum = {1'b0, alu_read1} + {1'b0, alu_foutput};
    case (alu_control)
      6'd16:     alu_out = alu_sum[W-1:0];
      6'd34:     alu_out = alu_read1 - alu_foutput;
      6'd36:     alu_out = alu_read1 & alu_foutput;
      6'd35:     alu_out = alu_read1 | alu_foutput;
      6'd39:     alu_out = ~(alu_read1 | alu_foutput);
      6'd42:     alu_out = ($signed(alu_read1) < $signed(alu_foutput)) ? 1 : 0;
      6'd4, 6'd5: alu_out = alu_read1 - alu_foutput;
      default:   alu_out = alu_read1 ^ alu_foutput ^ 32'h5A5A_A5A5;
    endcase
    alu_overflow = alu_sum[W];
    if (alu_control == 6'd4)      alu_zero = (alu_read1 == alu_foutput);
    else if (alu_control == 6'd5) alu_zero = (alu_read1 != alu_foutput);
    else                          alu_zero = (alu_out == '0);
  end

  function automatic exp_t ref_op(input logic [5:0] ctl, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
    exp_t e;
    logic [W:0] wide;
    e = '0;
    e.code = ctl;
    if (ctl == 6'd8)       e.code = 6'd16;
    else if (ctl == 6'd10) e.code = 6'd42;
    else if (ctl == 6'd12) e.code = 6'd36;
    else if (ctl == 6'd13) e.code = 6'd35;
    case (e.code)
      6'd16: begin
        wide = {1'b0, a} + {1'b0, b};
        e.result = wide[W-1:0];
        e.ovf = wide[W];
      end
      6'd34: e.result = a - b;
      6'd36: e.result = a & b;
      6'd35: e.result = a | b;
      6'd39: e.result = ~(a | b);
      6'd42: e.result = ($signed(a) < $signed(b)) ? 1 : 0;
      6'd4:  e.zero = (a == b);
      6'd5:  e.zero = (a != b);
      default: begin
        e.code = 6'd0;
        e.illegal = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic set_req(input int p, input logic [5:0] ctl, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    cur_ctl[p] = ctl;
    cur_a[p] = a;
    cur_b[p] = b;
  endtask

  task automatic model_step();
    logic [1:0] exp_rdy;
    exp_t e;
    int p;
    if (!m_busy) begin
      exp_rdy[0] = req_valid[0] && (!req_valid[1] || m_last == 1'b1);
      exp_rdy[1] = req_valid[1] && (!req_valid[0] || m_last == 1'b0);
      check("req_ready_idle", 64'(req_ready), 64'(exp_rdy));
      check("resp_valid_idle", 64'(resp_valid), 64'd0);
      if (exp_rdy != 2'b00) begin
        p = exp_rdy[1] ? 1 : 0;
        exp_q.push_back(ref_op(cur_ctl[p], cur_a[p], cur_b[p]));
        accepted[p] = 1'b1;
        m_busy = 1'b1;
        m_owner = exp_rdy[1];
        m_last = exp_rdy[1];
        m_hs = cyc;
      end
    end else begin
      e = exp_q[0];
      check("req_ready_busy", 64'(req_ready), 64'd0);
      if (cyc == m_hs + 1) begin
        check("alu_control_exec", 64'(alu_control), 64'(e.code));
        check("resp_valid_exec", 64'(resp_valid), 64'd0);
      end else begin
        check("resp_valid_owner", 64'(resp_valid), m_owner ? 64'd2 : 64'd1);
        check("resp_result_hold", 64'(resp_result), 64'(e.result));
        if (resp_ready[m_owner]) begin
          check("resp_flags", 64'({resp_illegal, resp_overflow, resp_zero}),
                64'({e.illegal, e.ovf, e.zero}));
          void'(exp_q.pop_front());
          m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic tick(input logic [1:0] rv, input logic [1:0] rr);
    req_valid = rv;
    resp_ready = rr;
    #1;
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] rand_ctl();
    logic [5:0] codes [12];
    codes = '{6'd16, 6'd8, 6'd34, 6'd36, 6'd12, 6'd35, 6'd13, 6'd39, 6'd42, 6'd10, 6'd4, 6'd5};
    if ($urandom_range(0, 7) == 0) return 6'($urandom_range(0, 63));
    return codes[$urandom_range(0, 11)];
  endfunction

  initial begin
    logic [1:0] rv;
    logic [W-1:0] a;
    for (int p = 0; p < 2; p++) begin
      set_req(p, 6'd0, '0, '0);
      accepted[p] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADDI overflow
    set_req(0, 6'd8, 32'hFFFF_FFFF, 32'h1);
    tick(2'b01, 2'b11);
    repeat (3) tick(2'b00, 2'b11);

    // contention: SUB 7-3 on port 0, SLT -1<2 on port 1
    set_req(0, 6'd34, 32'd7, 32'd3);
    set_req(1, 6'd42, 32'hFFFF_FFFF, 32'd2);
    repeat (12) tick(2'b11, 2'b11);
    repeat (3) tick(2'b00, 2'b11);

    // branch flags
    set_req(1, 6'd4, 32'h1234, 32'h1234);
    repeat (3) tick(2'b10, 2'b11);
    set_req(1, 6'd5, 32'h1234, 32'h1234);
    tick(2'b10, 2'b11);
    repeat (3) tick(2'b00, 2'b11);

    // response backpressure with port 1 waiting
    set_req(0, 6'd35, 32'hF0, 32'h0F);
    set_req(1, 6'd16, 32'd5, 32'd6);
    tick(2'b01, 2'b00);
    repeat (6) tick(2'b10, 2'b00);
    tick(2'b10, 2'b01);
    tick(2'b10, 2'b11);
    repeat (3) tick(2'b00, 2'b11);

    // illegal code
    set_req(0, 6'd63, 32'h55, 32'h55);
    tick(2'b01, 2'b11);
    repeat (3) tick(2'b00, 2'b11);

    // reset mid-RESP
    set_req(0, 6'd36, 32'hFF, 32'h0F);
    tick(2'b01, 2'b00);
    repeat (2) tick(2'b00, 2'b00);
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_result", 64'(resp_result), 64'd0);
    check("rst_resp_flags", 64'({resp_zero, resp_overflow, resp_illegal}), 64'd0);
    check("rst_alu_control", 64'(alu_control), 64'd0);
    check("rst_alu_operands", {alu_read1, alu_foutput}, 64'd0);
    exp_q.delete();
    m_busy = 1'b0;
    m_last = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick(2'b00, 2'b11);

    // random traffic
    rv = 2'b00;
    accepted[0] = 1'b0;
    accepted[1] = 1'b0;
    for (int k = 0; k < 800; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rv[p] || accepted[p]) begin
          accepted[p] = 1'b0;
          rv[p] = ($urandom_range(0, 2) != 0);
          a = rand_op();
          set_req(p, rand_ctl(), a, ($urandom_range(0, 3) == 0) ? a : rand_op());
        end
      end
      tick(rv, 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
